// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store path: tag, data and address types,
// the memory-op encoding and a helper giving the byte count of each op.
package load_store_unit_pkg;

  localparam int unsigned ROB_WIDTH = 4;

  typedef logic [ROB_WIDTH-1:0] ROB_TYPE;
  typedef logic [31:0]          DATA_TYPE;
  typedef logic [31:0]          ADDR_TYPE;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } OP_ENUM_TYPE;

  // Number of bytes moved over the byte port for an op.
  function automatic logic [2:0] op_bytes(input OP_ENUM_TYPE op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// lsu_extend: combinational sign/zero extension of an assembled load value.
//   op  : memory op (selects width and signedness)
//   raw : little-endian assembled bytes, unused upper bytes don't care
//   ext : extended 32-bit result
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  OP_ENUM_TYPE op,
  input  DATA_TYPE    raw,
  output DATA_TYPE    ext
);

  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  ext = {24'd0, raw[7:0]};
      OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: moves one load or store at a time over a shared
// byte-wide memory port, one byte per granted cycle, little-endian.
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   *_from_lsb : request (valid, direction, op, address, store data, rob tag)
//   busy_to_lsb, end_to_lsb, data_to_lsb : occupancy / completion / load data
//   *_to_cdb   : load result broadcast
//   mem_grant, mem_din, mem_a, mem_dout, mem_wr : byte memory port
//   roll_back_flag_from_rob : squash speculative loads
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        enable_from_lsb,
  input  logic        read_write_flag_from_lsb,
  input  OP_ENUM_TYPE op_enum_from_lsb,
  input  ADDR_TYPE    object_address_from_lsb,
  input  DATA_TYPE    data_from_lsb,
  input  ROB_TYPE     rob_id_from_lsb,
  output logic        busy_to_lsb,
  output logic        end_to_lsb,
  output DATA_TYPE    data_to_lsb,
  output logic        enable_to_cdb,
  output ROB_TYPE     rob_id_to_cdb,
  output DATA_TYPE    result_to_cdb,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output ADDR_TYPE    mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic        roll_back_flag_from_rob
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT_LAST, DONE} state_t;

  state_t      state;
  OP_ENUM_TYPE op_q;
  logic        is_store_q;
  ADDR_TYPE    addr_q;
  DATA_TYPE    data_q;
  ROB_TYPE     rob_q;
  logic [2:0]  k;
  logic [2:0]  n;
  DATA_TYPE    result_q;
  logic        pend;      // a read byte is due on mem_din this cycle
  logic [1:0]  pend_idx;  // which result byte it belongs to

  logic        grant_ok;
  DATA_TYPE    merged;
  DATA_TYPE    ext_result;

  // The port is driven straight from the byte counter so a grant is used in
  // the same cycle it is given; all state behind it is registered.
  assign grant_ok = rdy_in & mem_grant & (state == XFER);
  assign mem_wr   = grant_ok & is_store_q;
  assign mem_a    = addr_q + {29'd0, k};

  always_comb begin
    case (k[1:0])
      2'd0:    mem_dout = data_q[7:0];
      2'd1:    mem_dout = data_q[15:8];
      2'd2:    mem_dout = data_q[23:16];
      default: mem_dout = data_q[31:24];
    endcase
  end

  // Result with the byte arriving this cycle folded in; feeds both the
  // result register and the extender so the final byte reaches the outputs
  // on the same edge that enters DONE.
  always_comb begin
    merged = result_q;
    if (pend) begin
      case (pend_idx)
        2'd0:    merged[7:0]   = mem_din;
        2'd1:    merged[15:8]  = mem_din;
        2'd2:    merged[23:16] = mem_din;
        default: merged[31:24] = mem_din;
      endcase
    end
  end

  lsu_extend u_extend (
    .op  (op_q),
    .raw (merged),
    .ext (ext_result)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      op_q          <= OP_LB;
      is_store_q    <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      rob_q         <= '0;
      k             <= '0;
      n             <= '0;
      result_q      <= '0;
      pend          <= 1'b0;
      pend_idx      <= '0;
      busy_to_lsb   <= 1'b0;
      end_to_lsb    <= 1'b0;
      data_to_lsb   <= '0;
      enable_to_cdb <= 1'b0;
      rob_id_to_cdb <= '0;
      result_to_cdb <= '0;
    end else if (rdy_in) begin
      end_to_lsb    <= 1'b0;
      enable_to_cdb <= 1'b0;
      result_q      <= merged;
      pend          <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_from_lsb && !roll_back_flag_from_rob) begin
            op_q        <= op_enum_from_lsb;
            is_store_q  <= read_write_flag_from_lsb;
            addr_q      <= object_address_from_lsb;
            data_q      <= data_from_lsb;
            rob_q       <= rob_id_from_lsb;
            k           <= '0;
            n           <= op_bytes(op_enum_from_lsb);
            result_q    <= '0;
            busy_to_lsb <= 1'b1;
            state       <= XFER;
          end
        end
        XFER: begin
          if (roll_back_flag_from_rob && !is_store_q) begin
            busy_to_lsb <= 1'b0;
            state       <= IDLE;
          end else if (grant_ok) begin
            k        <= k + 3'd1;
            pend     <= !is_store_q;
            pend_idx <= k[1:0];
            if ((k + 3'd1) == n) begin
              if (is_store_q) begin
                end_to_lsb <= 1'b1;
                state      <= DONE;
              end else begin
                state <= WAIT_LAST;
              end
            end
          end
        end
        WAIT_LAST: begin
          if (roll_back_flag_from_rob) begin
            busy_to_lsb <= 1'b0;
            state       <= IDLE;
          end else begin
            end_to_lsb    <= 1'b1;
            enable_to_cdb <= 1'b1;
            data_to_lsb   <= ext_result;
            result_to_cdb <= ext_result;
            rob_id_to_cdb <= rob_q;
            state         <= DONE;
          end
        end
        default: begin
          busy_to_lsb <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte memory model, scoreboard of expected
// completions and writes, and one task per scenario.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        enable_from_lsb;
  logic        read_write_flag_from_lsb;
  OP_ENUM_TYPE op_enum_from_lsb;
  ADDR_TYPE    object_address_from_lsb;
  DATA_TYPE    data_from_lsb;
  ROB_TYPE     rob_id_from_lsb;
  logic        busy_to_lsb;
  logic        end_to_lsb;
  DATA_TYPE    data_to_lsb;
  logic        enable_to_cdb;
  ROB_TYPE     rob_id_to_cdb;
  DATA_TYPE    result_to_cdb;
  logic        mem_grant;
  logic [7:0]  mem_din;
  ADDR_TYPE    mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        roll_back_flag_from_rob;

  load_store_unit dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .rdy_in                   (rdy_in),
    .enable_from_lsb          (enable_from_lsb),
    .read_write_flag_from_lsb (read_write_flag_from_lsb),
    .op_enum_from_lsb         (op_enum_from_lsb),
    .object_address_from_lsb  (object_address_from_lsb),
    .data_from_lsb            (data_from_lsb),
    .rob_id_from_lsb          (rob_id_from_lsb),
    .busy_to_lsb              (busy_to_lsb),
    .end_to_lsb               (end_to_lsb),
    .data_to_lsb              (data_to_lsb),
    .enable_to_cdb            (enable_to_cdb),
    .rob_id_to_cdb            (rob_id_to_cdb),
    .result_to_cdb            (result_to_cdb),
    .mem_grant                (mem_grant),
    .mem_din                  (mem_din),
    .mem_a                    (mem_a),
    .mem_dout                 (mem_dout),
    .mem_wr                   (mem_wr),
    .roll_back_flag_from_rob  (roll_back_flag_from_rob)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic     is_load;
    DATA_TYPE data;
    ROB_TYPE  rob;
  } exp_t;

  typedef struct packed {
    ADDR_TYPE   a;
    logic [7:0] d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t exp_cur;
  wr_t  wr_cur;

  int n_vec  = 0;
  int n_miss = 0;
  int cur_cyc = 0;
  int ended_cyc = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  // Memory: read byte valid one cycle after its address, writes on grant.
  always @(posedge clk_in) begin
    mem_din <= mem[mem_a[15:0]];
    if (mem_wr) mem[mem_a[15:0]] <= mem_dout;
  end

  // Scoreboard monitor: checks every write and every completion pulse.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (mem_wr) begin
        n_vec++;
        if (wr_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_write: got a=%h d=%h, required no write", mem_a, mem_dout);
        end else begin
          wr_cur = wr_q.pop_front();
          if ({mem_a, mem_dout} !== {wr_cur.a, wr_cur.d}) begin
            n_miss++;
            $display("FAIL write: got a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, wr_cur.a, wr_cur.d);
          end
        end
      end
      if (end_to_lsb) begin
        ended_cyc = cur_cyc;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_end: end_to_lsb=1 in cycle %0d, required no completion", cur_cyc);
        end else begin
          exp_cur = exp_q.pop_front();
          if (enable_to_cdb !== exp_cur.is_load) begin
            n_miss++;
            $display("FAIL cdb_enable: got %b, required %b", enable_to_cdb, exp_cur.is_load);
          end
          if (exp_cur.is_load) begin
            n_vec += 3;
            if (data_to_lsb !== exp_cur.data) begin
              n_miss++;
              $display("FAIL load_data: got %h, required %h", data_to_lsb, exp_cur.data);
            end
            if (result_to_cdb !== exp_cur.data) begin
              n_miss++;
              $display("FAIL cdb_result: got %h, required %h", result_to_cdb, exp_cur.data);
            end
            if (rob_id_to_cdb !== exp_cur.rob) begin
              n_miss++;
              $display("FAIL cdb_rob: got %h, required %h", rob_id_to_cdb, exp_cur.rob);
            end
          end
        end
      end
    end
  end

  function automatic int unsigned model_bytes(input OP_ENUM_TYPE op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic DATA_TYPE model_load(input OP_ENUM_TYPE op, input ADDR_TYPE a);
    ADDR_TYPE t0, t1, t2, t3;
    logic [7:0] b0, b1, b2, b3;
    t0 = a; t1 = a + 32'd1; t2 = a + 32'd2; t3 = a + 32'd3;
    b0 = ref_mem[t0[15:0]]; b1 = ref_mem[t1[15:0]];
    b2 = ref_mem[t2[15:0]]; b3 = ref_mem[t3[15:0]];
    case (op)
      OP_LB:   return {{24{b0[7]}}, b0};
      OP_LBU:  return {24'd0, b0};
      OP_LH:   return {{16{b1[7]}}, b1, b0};
      OP_LHU:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic preload(input ADDR_TYPE a, input logic [7:0] b);
    mem[a[15:0]]     = b;
    ref_mem[a[15:0]] = b;
  endtask

  task automatic expect_store(input OP_ENUM_TYPE op, input ADDR_TYPE a, input DATA_TYPE d);
    ADDR_TYPE   t;
    logic [7:0] b;
    DATA_TYPE   sh;
    for (int unsigned i = 0; i < model_bytes(op); i++) begin
      t  = a + i;
      sh = d >> (8 * i);
      b  = sh[7:0];
      wr_q.push_back('{a: t, d: b});
      ref_mem[t[15:0]] = b;
    end
    exp_q.push_back('{is_load: 1'b0, data: '0, rob: '0});
  endtask

  task automatic expect_load(input DATA_TYPE d, input ROB_TYPE rob);
    exp_q.push_back('{is_load: 1'b1, data: d, rob: rob});
  endtask

  // Entered and left at negedge+1. Request is sampled at the end of cycle 0.
  task automatic drive_txn(input OP_ENUM_TYPE op, input ADDR_TYPE addr, input DATA_TYPE data,
                           input ROB_TYPE rob, input int stall_lo, input int stall_hi,
                           input int roll_cyc, input int max_cyc, output int end_cyc);
    enable_from_lsb          = 1'b1;
    read_write_flag_from_lsb = (op == OP_SB || op == OP_SH || op == OP_SW);
    op_enum_from_lsb         = op;
    object_address_from_lsb  = addr;
    data_from_lsb            = data;
    rob_id_from_lsb          = rob;
    mem_grant                = 1'b1;
    roll_back_flag_from_rob  = (roll_cyc == 0);
    ended_cyc = 0;
    cur_cyc   = 0;
    @(posedge clk_in); #1;
    enable_from_lsb = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c > 1) begin @(posedge clk_in); #1; end
      cur_cyc                 = c;
      mem_grant               = !(c >= stall_lo && c <= stall_hi);
      roll_back_flag_from_rob = (c == roll_cyc);
      @(negedge clk_in); #1;
      if (ended_cyc != 0) break;
    end
    @(posedge clk_in); #1;
    cur_cyc++;
    roll_back_flag_from_rob = 1'b0;
    mem_grant = 1'b1;
    @(negedge clk_in); #1;
    end_cyc = ended_cyc;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    n_vec += 6;
    if (busy_to_lsb !== 1'b0)    begin n_miss++; $display("FAIL reset_busy: got %b, required 0", busy_to_lsb); end
    if (end_to_lsb !== 1'b0)     begin n_miss++; $display("FAIL reset_end: got %b, required 0", end_to_lsb); end
    if (enable_to_cdb !== 1'b0)  begin n_miss++; $display("FAIL reset_cdb: got %b, required 0", enable_to_cdb); end
    if (mem_wr !== 1'b0)         begin n_miss++; $display("FAIL reset_mem_wr: got %b, required 0", mem_wr); end
    if ({mem_a, mem_dout} !== 40'd0) begin n_miss++; $display("FAIL reset_mem_port: got a=%h d=%h, required 0", mem_a, mem_dout); end
    if ({data_to_lsb, result_to_cdb, rob_id_to_cdb} !== '0) begin
      n_miss++;
      $display("FAIL reset_results: got %h %h %h, required 0", data_to_lsb, result_to_cdb, rob_id_to_cdb);
    end
    @(negedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in); #1;
  endtask

  task automatic test_lw;
    int e;
    preload(32'h1000, 8'h78); preload(32'h1001, 8'h56);
    preload(32'h1002, 8'h34); preload(32'h1003, 8'h12);
    expect_load(32'h1234_5678, 4'd5);
    drive_txn(OP_LW, 32'h1000, '0, 4'd5, 0, -1, -1, 12, e);
    n_vec += 2;
    if (e !== 6) begin n_miss++; $display("FAIL lw_latency: end in cycle %0d, required 6", e); end
    if (busy_to_lsb !== 1'b0 || end_to_lsb !== 1'b0) begin
      n_miss++; $display("FAIL lw_after: busy=%b end=%b, required 0 0", busy_to_lsb, end_to_lsb);
    end
  endtask

  task automatic test_extend;
    int e;
    preload(32'h3003, 8'h80); preload(32'h3004, 8'hC1);
    expect_load(32'hFFFF_FF80, 4'd1);
    drive_txn(OP_LB, 32'h3003, '0, 4'd1, 0, -1, -1, 10, e);
    n_vec++; if (e !== 3) begin n_miss++; $display("FAIL lb_latency: end in cycle %0d, required 3", e); end
    expect_load(32'h0000_0080, 4'd2);
    drive_txn(OP_LBU, 32'h3003, '0, 4'd2, 0, -1, -1, 10, e);
    n_vec++; if (e !== 3) begin n_miss++; $display("FAIL lbu_latency: end in cycle %0d, required 3", e); end
    expect_load(model_load(OP_LH, 32'h3003), 4'd3);
    drive_txn(OP_LH, 32'h3003, '0, 4'd3, 0, -1, -1, 10, e);
    n_vec++; if (e !== 4) begin n_miss++; $display("FAIL lh_latency: end in cycle %0d, required 4", e); end
    expect_load(model_load(OP_LHU, 32'h3003), 4'd4);
    drive_txn(OP_LHU, 32'h3003, '0, 4'd4, 0, -1, -1, 10, e);
    n_vec++; if (e !== 4) begin n_miss++; $display("FAIL lhu_latency: end in cycle %0d, required 4", e); end
  endtask

  task automatic test_store;
    int e;
    expect_store(OP_SH, 32'h2001, 32'h0000_BEEF);
    drive_txn(OP_SH, 32'h2001, 32'h0000_BEEF, 4'd6, 0, -1, -1, 10, e);
    n_vec += 2;
    if (e !== 3) begin n_miss++; $display("FAIL sh_latency: end in cycle %0d, required 3", e); end
    if (wr_q.size() != 0) begin n_miss++; $display("FAIL sh_writes: %0d writes missing, required 0", wr_q.size()); end
    expect_store(OP_SB, 32'h2010, 32'h0000_00A5);
    drive_txn(OP_SB, 32'h2010, 32'h0000_00A5, 4'd7, 0, -1, -1, 10, e);
    n_vec++; if (e !== 2) begin n_miss++; $display("FAIL sb_latency: end in cycle %0d, required 2", e); end
    // Misaligned word crossing the top of the address space.
    expect_store(OP_SW, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    drive_txn(OP_SW, 32'hFFFF_FFFE, 32'hCAFE_F00D, 4'd8, 0, -1, -1, 10, e);
    n_vec++; if (e !== 5) begin n_miss++; $display("FAIL sw_latency: end in cycle %0d, required 5", e); end
    expect_load(32'hCAFE_F00D, 4'd9);
    drive_txn(OP_LW, 32'hFFFF_FFFE, '0, 4'd9, 0, -1, -1, 12, e);
    n_vec++; if (e !== 6) begin n_miss++; $display("FAIL lw_wrap_latency: end in cycle %0d, required 6", e); end
  endtask

  task automatic test_stall;
    int e;
    expect_load(32'h1234_5678, 4'd10);
    drive_txn(OP_LW, 32'h1000, '0, 4'd10, 2, 3, -1, 14, e);
    n_vec++; if (e !== 8) begin n_miss++; $display("FAIL stall_latency: end in cycle %0d, required 8", e); end
  endtask

  task automatic test_rollback;
    int e;
    drive_txn(OP_LH, 32'h3003, '0, 4'd11, 0, -1, 2, 2, e);
    n_vec += 2;
    if (e !== 0) begin n_miss++; $display("FAIL rb_load_end: end in cycle %0d, required none", e); end
    if (busy_to_lsb !== 1'b0) begin n_miss++; $display("FAIL rb_load_idle: busy=%b in cycle 3, required 0", busy_to_lsb); end
    expect_load(32'h0000_0080, 4'd12);
    drive_txn(OP_LBU, 32'h3003, '0, 4'd12, 0, -1, -1, 10, e);
    n_vec++; if (e !== 3) begin n_miss++; $display("FAIL rb_next_req: end in cycle %0d, required 3", e); end
    // Rollback coincident with the request in IDLE drops it.
    drive_txn(OP_LW, 32'h1000, '0, 4'd13, 0, -1, 0, 1, e);
    n_vec++;
    if (busy_to_lsb !== 1'b0 || e !== 0) begin
      n_miss++; $display("FAIL rb_idle_drop: busy=%b end_cycle=%0d, required 0 0", busy_to_lsb, e);
    end
    expect_store(OP_SW, 32'h5000, 32'h1122_3344);
    drive_txn(OP_SW, 32'h5000, 32'h1122_3344, 4'd14, 0, -1, 2, 10, e);
    n_vec += 2;
    if (e !== 5) begin n_miss++; $display("FAIL rb_store_end: end in cycle %0d, required 5", e); end
    if (wr_q.size() != 0) begin n_miss++; $display("FAIL rb_store_writes: %0d writes missing, required 0", wr_q.size()); end
  endtask

  task automatic test_reset_mid;
    int e;
    bit stray;
    drive_txn(OP_LW, 32'h1000, '0, 4'd15, 0, -1, -1, 2, e);
    n_vec++;
    if (busy_to_lsb !== 1'b1) begin n_miss++; $display("FAIL mid_busy: got %b, required 1", busy_to_lsb); end
    rst_in = 1'b1;
    #1;
    n_vec += 2;
    if (busy_to_lsb !== 1'b0) begin n_miss++; $display("FAIL mid_rst_busy: got %b, required 0", busy_to_lsb); end
    if (mem_wr !== 1'b0)      begin n_miss++; $display("FAIL mid_rst_mem_wr: got %b, required 0", mem_wr); end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    stray = 1'b0;
    repeat (8) begin
      @(negedge clk_in); #1;
      if (end_to_lsb !== 1'b0 || enable_to_cdb !== 1'b0 || busy_to_lsb !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin n_miss++; $display("FAIL mid_rst_pulse: activity after reset, required none"); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rdy_in = 1'b1; enable_from_lsb = 1'b0; read_write_flag_from_lsb = 1'b0;
    op_enum_from_lsb = OP_LB; object_address_from_lsb = '0; data_from_lsb = '0;
    rob_id_from_lsb = '0; mem_grant = 1'b0; roll_back_flag_from_rob = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset;
    test_lw;
    test_extend;
    test_store;
    test_stall;
    test_rollback;
    test_reset_mid;
    n_vec++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover: %0d completions, %0d writes outstanding, required 0 0", exp_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
